// File: rtl/match_controller.sv
// rtl/match_controller.sv - best-of-N match sequencer: countdown, timed rounds, tallies, hold-to-restart
module match_controller #(
    parameter int HP_W             = 9,
    parameter int WINS_TO_MATCH    = 2,
    parameter int ROUND_SECS       = 99,
    parameter int TICKS_PER_SEC    = 20,
    parameter int COUNTDOWN_TICKS  = 60,
    parameter int ROUND_OVER_TICKS = 40,
    parameter int HOLD_TICKS       = 40,
    localparam int W               = $clog2(WINS_TO_MATCH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [HP_W-1:0] health_1,
    input  logic [HP_W-1:0] health_2,
    input  logic            reset_req,
    output logic [2:0]      state,
    output logic            round_reset,
    output logic            game_active,
    output logic [1:0]      round_winner,
    output logic [1:0]      match_winner,
    output logic [W-1:0]    p1_wins,
    output logic [W-1:0]    p2_wins,
    output logic [6:0]      round_time
);

    // One shared phase counter serves both the countdown and the post-round pause.
    localparam int CNT_MAX = (COUNTDOWN_TICKS > ROUND_OVER_TICKS) ? COUNTDOWN_TICKS : ROUND_OVER_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW      = $clog2(HOLD_TICKS + 1);

    localparam logic [CW-1:0] CD_LOAD   = CW'(COUNTDOWN_TICKS);
    localparam logic [CW-1:0] RO_LOAD   = CW'(ROUND_OVER_TICKS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [6:0]    TIME_LOAD = 7'(ROUND_SECS);
    localparam logic [SW-1:0] SUB_LAST  = SW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_TICKS);
    localparam logic [W-1:0]  WINS_FULL = W'(WINS_TO_MATCH);

    typedef enum logic [2:0] {
        S_COUNTDOWN  = 3'd0,
        S_FIGHT      = 3'd1,
        S_ROUND_OVER = 3'd2,
        S_MATCH_OVER = 3'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [SW-1:0]   sub_q;
    logic [HW-1:0]   hold_q;
    logic [1:0]      outcome;
    logic            restart;
    logic            match_decided;
    logic            fight_start;
    logic            round_end;
    logic            pause_done;

    assign state         = state_q;
    assign round_reset   = (state_q == S_COUNTDOWN);
    assign game_active   = (state_q == S_FIGHT);
    assign restart       = (hold_q == HOLD_FULL);
    assign match_decided = (p1_wins == WINS_FULL) || (p2_wins == WINS_FULL);

    // Round judging: knockouts take priority over the timeout comparison.
    always_comb begin
        outcome = 2'b00;
        if (health_1 == '0 && health_2 == '0) begin
            outcome = 2'b11;
        end else if (health_1 == '0) begin
            outcome = 2'b10;
        end else if (health_2 == '0) begin
            outcome = 2'b01;
        end else if (round_time == 7'd0) begin
            if (health_1 > health_2) begin
                outcome = 2'b01;
            end else if (health_2 > health_1) begin
                outcome = 2'b10;
            end else begin
                outcome = 2'b11;
            end
        end
    end

    // Next-state decode and the phase events the datapath reacts to.
    always_comb begin
        state_d     = state_q;
        fight_start = 1'b0;
        round_end   = 1'b0;
        pause_done  = 1'b0;
        case (state_q)
            S_COUNTDOWN: begin
                if (tick && cnt_q == CNT_ONE) begin
                    state_d     = S_FIGHT;
                    fight_start = 1'b1;
                end
            end
            S_FIGHT: begin
                if (outcome != 2'b00) begin
                    state_d   = S_ROUND_OVER;
                    round_end = 1'b1;
                end
            end
            S_ROUND_OVER: begin
                if (tick && cnt_q == CNT_ONE) begin
                    pause_done = 1'b1;
                    state_d    = match_decided ? S_MATCH_OVER : S_COUNTDOWN;
                end
            end
            S_MATCH_OVER: begin
                state_d = S_MATCH_OVER;
            end
            default: begin
                state_d = S_COUNTDOWN;
            end
        endcase
    end

    // State register; a completed restart hold behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q <= S_COUNTDOWN;
        end else begin
            state_q <= state_d;
        end
    end

    // Restart hold counter: counts ticks of a continuous reset_req level.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            hold_q <= '0;
        end else if (!reset_req) begin
            hold_q <= '0;
        end else if (tick && hold_q != HOLD_FULL) begin
            hold_q <= hold_q + HW'(1);
        end
    end

    // Phase counter, sub-second divider and round timer.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_q      <= CD_LOAD;
            sub_q      <= '0;
            round_time <= TIME_LOAD;
        end else begin
            case (state_q)
                S_COUNTDOWN: begin
                    if (tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                    if (fight_start) begin
                        round_time <= TIME_LOAD;
                        sub_q      <= '0;
                    end
                end
                S_FIGHT: begin
                    if (round_end) begin
                        cnt_q <= RO_LOAD;
                    end else if (tick) begin
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (round_time != 7'd0) begin
                                round_time <= round_time - 7'd1;
                            end
                        end else begin
                            sub_q <= sub_q + SW'(1);
                        end
                    end
                end
                S_ROUND_OVER: begin
                    if (pause_done) begin
                        cnt_q <= CD_LOAD;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    // Round result, saturating tallies and final match verdict.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            round_winner <= 2'b00;
            match_winner <= 2'b00;
            p1_wins      <= '0;
            p2_wins      <= '0;
        end else begin
            if (round_end) begin
                round_winner <= outcome;
                if (outcome == 2'b01 && p1_wins != WINS_FULL) begin
                    p1_wins <= p1_wins + W'(1);
                end
                if (outcome == 2'b10 && p2_wins != WINS_FULL) begin
                    p2_wins <= p2_wins + W'(1);
                end
            end
            if (pause_done && match_decided) begin
                match_winner <= (p1_wins == WINS_FULL) ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - scoreboard bench for match_controller with a behavioural match model
module tb_match_controller;

    localparam int HP_W = 9;
    localparam int WINS = 2;
    localparam int RS   = 2;
    localparam int TPS  = 5;
    localparam int CD   = 6;
    localparam int RO   = 4;
    localparam int HOLD = 8;
    localparam int WW   = $clog2(WINS + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
    logic            reset_req = 1'b0;
    logic [HP_W-1:0] health_1 = 9'd200;
    logic [HP_W-1:0] health_2 = 9'd200;
    logic [2:0]      state;
    logic            round_reset;
    logic            game_active;
    logic [1:0]      round_winner;
    logic [1:0]      match_winner;
    logic [WW-1:0]   p1_wins;
    logic [WW-1:0]   p2_wins;
    logic [6:0]      round_time;

    match_controller #(
        .HP_W(HP_W), .WINS_TO_MATCH(WINS), .ROUND_SECS(RS), .TICKS_PER_SEC(TPS),
        .COUNTDOWN_TICKS(CD), .ROUND_OVER_TICKS(RO), .HOLD_TICKS(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .health_1(health_1), .health_2(health_2),
        .reset_req(reset_req), .state(state), .round_reset(round_reset), .game_active(game_active),
        .round_winner(round_winner), .match_winner(match_winner), .p1_wins(p1_wins),
        .p2_wins(p2_wins), .round_time(round_time)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          rr;
        logic          ga;
        logic [1:0]    rw;
        logic [1:0]    mw;
        logic [WW-1:0] w1;
        logic [WW-1:0] w2;
        logic [6:0]    rt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_cycle = 0;

    // Reference model of the match in plain integers: phase 0..3, ticks left in the current
    // countdown/pause, ticks into the current second, seconds left, hold ticks, tallies, results.
    int m_phase, m_left, m_sub, m_time, m_hold, m_w1, m_w2, m_rw, m_mw;

    function automatic int judge(input int h1, input int h2, input int secs);
        if (h1 == 0 && h2 == 0) return 3;
        if (h1 == 0) return 2;
        if (h2 == 0) return 1;
        if (secs == 0) return (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
        return 0;
    endfunction

    function automatic void model_step(input bit rst, input bit tk, input int h1, input int h2, input bit rq);
        int verdict;
        if (rst || m_hold >= HOLD) begin
            m_phase = 0; m_left = CD; m_sub = 0; m_time = RS; m_hold = 0;
            m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0;
            return;
        end
        if (!rq) m_hold = 0;
        else if (tk && m_hold < HOLD) m_hold = m_hold + 1;
        case (m_phase)
            0: if (tk) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_phase = 1; m_time = RS; m_sub = 0; end
            end
            1: begin
                verdict = judge(h1, h2, m_time);
                if (verdict != 0) begin
                    m_rw = verdict;
                    if (verdict == 1 && m_w1 < WINS) m_w1 = m_w1 + 1;
                    if (verdict == 2 && m_w2 < WINS) m_w2 = m_w2 + 1;
                    m_left = RO;
                    m_phase = 2;
                end else if (tk) begin
                    m_sub = m_sub + 1;
                    if (m_sub == TPS) begin
                        m_sub = 0;
                        if (m_time > 0) m_time = m_time - 1;
                    end
                end
            end
            2: if (tk) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_w1 == WINS || m_w2 == WINS) begin
                        m_phase = 3;
                        m_mw = (m_w1 == WINS) ? 1 : 2;
                    end else begin
                        m_phase = 0;
                        m_left = CD;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_phase);
        o.rr = (m_phase == 0);
        o.ga = (m_phase == 1);
        o.rw = 2'(m_rw);
        o.mw = 2'(m_mw);
        o.w1 = WW'(m_w1);
        o.w2 = WW'(m_w2);
        o.rt = 7'(m_time);
        return o;
    endfunction

    // Drive one clock of stimulus and queue the response the model expects after that edge.
    task automatic cyc(input bit rst, input bit tk, input int h1, input int h2, input bit rq);
        @(negedge clk);
        reset     = rst;
        tick      = tk;
        health_1  = HP_W'(h1);
        health_2  = HP_W'(h2);
        reset_req = rq;
        model_step(rst, tk, h1, h2, rq);
        exp_q.push_back(model_obs());
    endtask

    task automatic run_ticks(input int n, input int per, input int h1, input int h2, input bit rq);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, h1, h2, rq);
            for (int j = 1; j < per; j++) cyc(1'b0, 1'b0, h1, h2, rq);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks = n_checks + 1;
        if (act == expv) n_pass = n_pass + 1;
        else $display("FAIL %s got %0d expected %0d", name, act, expv);
    endtask

    // Monitor: every clock the DUT presents a new snapshot; compare it with the oldest prediction.
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, round_reset, game_active, round_winner, match_winner, p1_wins, p2_wins, round_time};
                n_checks = n_checks + 1;
                n_cycle  = n_cycle + 1;
                if (a === e) n_pass = n_pass + 1;
                else $display("FAIL scoreboard cycle=%0d got st=%0d rr=%0d ga=%0d rw=%0d mw=%0d w=%0d/%0d rt=%0d expected st=%0d rr=%0d ga=%0d rw=%0d mw=%0d w=%0d/%0d rt=%0d",
                              n_cycle, a.st, a.rr, a.ga, a.rw, a.mw, a.w1, a.w2, a.rt,
                              e.st, e.rr, e.ga, e.rw, e.mw, e.w1, e.w2, e.rt);
            end
        end
    end

    function automatic int pick_health();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 90;
            2:       return 150;
            5:       return int'($urandom_range(1, 511));
            default: return 200;
        endcase
    endfunction

    initial begin : stimulus
        int h1, h2, rq_len, tick_per;
        bit tk, rq;

        cyc(1'b1, 1'b0, 200, 200, 1'b0);
        cyc(1'b1, 1'b0, 200, 200, 1'b0);
        settle();
        check("reset_state", state, 0);
        check("reset_round_reset", round_reset, 1);
        check("reset_game_active", game_active, 0);
        check("reset_round_time", round_time, RS);
        check("reset_round_winner", round_winner, 0);
        check("reset_match_winner", match_winner, 0);

        run_ticks(CD - 1, 4, 200, 200, 1'b0);
        settle();
        check("countdown_still", state, 0);
        run_ticks(1, 4, 200, 200, 1'b0);
        settle();
        check("fight_entry", state, 1);
        check("fight_time", round_time, RS);
        run_ticks(TPS, 4, 200, 200, 1'b0);
        settle();
        check("one_second", round_time, RS - 1);

        cyc(1'b0, 1'b0, 200, 0, 1'b0);
        settle();
        check("ko_state", state, 2);
        check("ko_winner", round_winner, 1);
        check("ko_tally", p1_wins, 1);
        run_ticks(RO - 1, 4, 200, 200, 1'b0);
        settle();
        check("pause_still", state, 2);
        run_ticks(1, 4, 200, 200, 1'b0);
        settle();
        check("pause_done", state, 0);
        check("winner_kept", round_winner, 1);

        run_ticks(CD, 4, 200, 200, 1'b0);
        cyc(1'b0, 1'b0, 200, 0, 1'b0);
        run_ticks(RO, 4, 200, 200, 1'b0);
        settle();
        check("match_over", state, 3);
        check("match_winner", match_winner, 1);
        check("match_tally", p1_wins, 2);
        run_ticks(20, 4, 200, 200, 1'b0);
        settle();
        check("terminal", state, 3);

        run_ticks(HOLD - 1, 4, 200, 200, 1'b1);
        cyc(1'b0, 1'b0, 200, 200, 1'b0);
        run_ticks(HOLD - 1, 4, 200, 200, 1'b1);
        settle();
        check("hold_not_yet", state, 3);
        run_ticks(1, 4, 200, 200, 1'b1);
        settle();
        check("restart_state", state, 0);
        check("restart_tally", p1_wins, 0);
        check("restart_match_winner", match_winner, 0);

        run_ticks(CD, 4, 150, 90, 1'b0);
        run_ticks(RS * TPS - 1, 4, 150, 90, 1'b0);
        settle();
        check("timeout_pending", state, 1);
        check("timeout_time", round_time, 1);
        run_ticks(1, 4, 150, 90, 1'b0);
        settle();
        check("timeout_state", state, 2);
        check("timeout_winner", round_winner, 1);
        run_ticks(RO, 4, 90, 90, 1'b0);
        run_ticks(CD, 4, 90, 90, 1'b0);
        run_ticks(RS * TPS, 4, 90, 90, 1'b0);
        settle();
        check("timeout_draw", round_winner, 3);
        check("draw_p1", p1_wins, 1);
        check("draw_p2", p2_wins, 0);

        run_ticks(RO, 4, 200, 200, 1'b0);
        run_ticks(CD, 4, 200, 200, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        settle();
        check("double_ko", round_winner, 3);
        check("double_ko_p1", p1_wins, 1);
        check("double_ko_p2", p2_wins, 0);

        run_ticks(RO, 4, 200, 200, 1'b0);
        run_ticks(CD, 4, 200, 200, 1'b1);
        run_ticks(1, 4, 200, 200, 1'b1);
        cyc(1'b0, 1'b1, 200, 200, 1'b1);
        cyc(1'b0, 1'b0, 200, 0, 1'b1);
        settle();
        check("restart_beats_ko_state", state, 0);
        check("restart_beats_ko_winner", round_winner, 0);

        run_ticks(CD, 4, 200, 200, 1'b0);
        cyc(1'b0, 1'b0, 200, 0, 1'b0);
        run_ticks(RO, 4, 200, 200, 1'b0);
        run_ticks(CD, 4, 200, 200, 1'b0);
        settle();
        check("midround_pre", p1_wins, 1);
        cyc(1'b1, 1'b0, 200, 0, 1'b0);
        settle();
        check("midround_reset_state", state, 0);
        check("midround_reset_tally", p1_wins, 0);

        cyc(1'b0, 1'b0, 200, 200, 1'b0);
        run_ticks(CD - 1, 1, 200, 200, 1'b0);
        settle();
        check("stuck_tick_countdown", state, 0);
        run_ticks(1, 1, 200, 200, 1'b0);
        settle();
        check("stuck_tick_fight", state, 1);

        h1 = 200; h2 = 200; rq_len = 0; tick_per = 1;
        for (int i = 0; i < 30000; i++) begin
            if (i % 500 == 0) tick_per = $urandom_range(1, 4);
            if (tick_per == 4) tk = 1'($urandom_range(0, 1));
            else tk = (i % tick_per == 0);
            if ($urandom_range(0, 39) == 0) h1 = pick_health();
            if ($urandom_range(0, 39) == 0) h2 = pick_health();
            if (rq_len > 0) begin
                rq_len = rq_len - 1;
                rq = 1'b1;
            end else begin
                rq = 1'b0;
                if ($urandom_range(0, 299) == 0) rq_len = $urandom_range(1, 80);
            end
            cyc($urandom_range(0, 2999) == 0, tk, h1, h2, rq);
        end
        settle();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
